// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline advance/stall/flush control: merges split cache hits into one tick,
// tracks in-flight loads across EX and MEM, and freezes permanently on halt.
module pipeline_hazard_ctrl #(
    parameter int REGW = 5,
    parameter int WORD = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            dmem_req,
    input  logic [WORD-1:0] id_instr,
    input  logic            id_uses_rt,
    input  logic            id_is_load,
    input  logic [REGW-1:0] id_dest,
    input  logic            branch_taken,
    input  logic            halt,
    output logic            tick,
    output logic            lw_hazard,
    output logic [1:0]      lw_later_hazard,
    output logic            branching,
    output logic            halted
);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            i_done_r;
    logic            d_done_r;
    logic            ex_vld_r;
    logic [REGW-1:0] ex_reg_r;
    logic            mem_vld_r;
    logic [REGW-1:0] mem_reg_r;
    logic [REGW-1:0] rs_s;
    logic [REGW-1:0] rt_s;
    logic            run_s;
    logic            unused_instr_s;

    assign rs_s           = id_instr[21 +: REGW];
    assign rt_s           = id_instr[16 +: REGW];
    assign unused_instr_s = ^{id_instr[WORD-1:26], id_instr[15:0]};

    // Register 0 is hard-wired, so a tracked load into it never matches.
    function automatic logic reg_hit(input logic vld, input logic [REGW-1:0] trk,
                                     input logic [REGW-1:0] src);
        return vld & (trk != {REGW{1'b0}}) & (src == trk);
    endfunction

    // State register: HALT is left only through reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN:  state_nxt_s = halt ? ST_HALT : ST_RUN;
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Outputs; gated with nRST so nothing leaks out while reset is held.
    always_comb begin
        run_s           = (state_r == ST_RUN) & nRST;
        tick            = run_s & (ihit | i_done_r) & (~dmem_req | dhit | d_done_r);
        branching       = run_s & branch_taken;
        lw_hazard       = run_s & ~branch_taken &
                          (reg_hit(ex_vld_r, ex_reg_r, rs_s) |
                           (id_uses_rt & reg_hit(ex_vld_r, ex_reg_r, rt_s)));
        lw_later_hazard = {run_s & id_uses_rt & reg_hit(mem_vld_r, mem_reg_r, rt_s),
                           run_s & reg_hit(mem_vld_r, mem_reg_r, rs_s)};
        halted          = (state_r == ST_HALT);
    end

    // Hit flags hold an early hit until its partner arrives and the pipeline ticks.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            i_done_r <= 1'b0;
            d_done_r <= 1'b0;
        end else if (state_r == ST_HALT) begin
            i_done_r <= i_done_r;
            d_done_r <= d_done_r;
        end else if (tick) begin
            i_done_r <= 1'b0;
            d_done_r <= 1'b0;
        end else begin
            i_done_r <= i_done_r | ihit;
            d_done_r <= d_done_r | (dhit & dmem_req);
        end
    end

    // Load tracker advances with the pipeline; bubbles and flushed slots enter invalid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_vld_r  <= 1'b0;
            ex_reg_r  <= {REGW{1'b0}};
            mem_vld_r <= 1'b0;
            mem_reg_r <= {REGW{1'b0}};
        end else if (tick) begin
            ex_vld_r  <= id_is_load & ~lw_hazard & ~branching;
            ex_reg_r  <= id_dest;
            mem_vld_r <= ex_vld_r;
            mem_reg_r <= ex_reg_r;
        end else begin
            ex_vld_r  <= ex_vld_r;
            ex_reg_r  <= ex_reg_r;
            mem_vld_r <= mem_vld_r;
            mem_reg_r <= mem_reg_r;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl: inputs change on the
// falling edge and outputs are sampled 1 time unit later, before the rising edge.
module tb_pipeline_hazard_ctrl;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic        dhit;
    logic        dmem_req;
    logic [31:0] id_instr;
    logic        id_uses_rt;
    logic        id_is_load;
    logic [4:0]  id_dest;
    logic        branch_taken;
    logic        halt;
    logic        tick;
    logic        lw_hazard;
    logic [1:0]  lw_later_hazard;
    logic        branching;
    logic        halted;

    int passed;
    int total;

    pipeline_hazard_ctrl #(.REGW(5), .WORD(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .id_instr(id_instr), .id_uses_rt(id_uses_rt), .id_is_load(id_is_load),
        .id_dest(id_dest), .branch_taken(branch_taken), .halt(halt),
        .tick(tick), .lw_hazard(lw_hazard), .lw_later_hazard(lw_later_hazard),
        .branching(branching), .halted(halted)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
        return {6'd0, rs, rt, 16'd0};
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic e_tick, input logic e_lw,
                           input logic [1:0] e_later, input logic e_br, input logic e_halted);
        chk({tag, ".tick"},    {3'd0, tick},            {3'd0, e_tick});
        chk({tag, ".lw"},      {3'd0, lw_hazard},       {3'd0, e_lw});
        chk({tag, ".later"},   {2'd0, lw_later_hazard}, {2'd0, e_later});
        chk({tag, ".branch"},  {3'd0, branching},       {3'd0, e_br});
        chk({tag, ".halted"},  {3'd0, halted},          {3'd0, e_halted});
    endtask

    initial begin
        passed = 0;
        total  = 0;
        nRST = 1'b0; ihit = 1'b1; dhit = 1'b1; dmem_req = 1'b1; branch_taken = 1'b1;
        halt = 1'b0; id_instr = 32'd0; id_uses_rt = 1'b0; id_is_load = 1'b0; id_dest = 5'd0;
        #1 chk_all("reset", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Fetch-only ticks
        @(negedge CLK);
        nRST = 1'b1; dhit = 1'b0; dmem_req = 1'b0; branch_taken = 1'b0; ihit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk_all("ifetch", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
            @(negedge CLK);
        end

        // ihit first, dhit three cycles later
        dmem_req = 1'b1; ihit = 1'b1;
        #1 chk("split_i.c2", {3'd0, tick}, 4'd0);
        @(negedge CLK); ihit = 1'b0;
        #1 chk("split_i.c3", {3'd0, tick}, 4'd0);
        @(negedge CLK);
        #1 chk("split_i.c4", {3'd0, tick}, 4'd0);
        @(negedge CLK); dhit = 1'b1;
        #1 chk("split_i.c5", {3'd0, tick}, 4'd1);
        @(negedge CLK); dhit = 1'b0;
        #1 chk("split_i.clear", {3'd0, tick}, 4'd0);

        // dhit first, ihit later
        @(negedge CLK); dhit = 1'b1;
        #1 chk("split_d.c1", {3'd0, tick}, 4'd0);
        @(negedge CLK); dhit = 1'b0;
        #1 chk("split_d.c2", {3'd0, tick}, 4'd0);
        @(negedge CLK); ihit = 1'b1;
        #1 chk("split_d.c3", {3'd0, tick}, 4'd1);
        @(negedge CLK); ihit = 1'b0;
        #1 chk("split_d.clear", {3'd0, tick}, 4'd0);

        // dhit without a memory request is ignored
        @(negedge CLK); dmem_req = 1'b0; dhit = 1'b1;
        #1 chk("dhit_noreq", {3'd0, tick}, 4'd0);
        @(negedge CLK); dmem_req = 1'b1; dhit = 1'b0; ihit = 1'b1;
        #1 chk("dhit_noreq.later", {3'd0, tick}, 4'd0);
        @(negedge CLK); ihit = 1'b0; dhit = 1'b1;
        #1 chk("dhit_noreq.done", {3'd0, tick}, 4'd1);

        // Load r8, then consumer with rs=8
        @(negedge CLK); dmem_req = 1'b0; dhit = 1'b0; ihit = 1'b1;
        id_is_load = 1'b1; id_dest = 5'd8;
        #1 chk("ld8.tick", {3'd0, tick}, 4'd1);
        @(negedge CLK); id_is_load = 1'b0; id_dest = 5'd9; id_instr = mk(5'd8, 5'd1); id_uses_rt = 1'b1;
        #1 chk_all("ld8.use", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        @(negedge CLK);
        #1 chk_all("ld8.fwd", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
        @(negedge CLK);
        #1 chk_all("ld8.gone", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

        // Load r5, consumer reads it via rt
        @(negedge CLK); id_is_load = 1'b1; id_dest = 5'd5; id_instr = 32'd0; id_uses_rt = 1'b0;
        @(negedge CLK); id_is_load = 1'b0; id_dest = 5'd0; ihit = 1'b0; id_instr = mk(5'd0, 5'd5);
        #1 chk_all("ld5.rt_unused", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        id_uses_rt = 1'b1;
        #1 chk_all("ld5.rt_wait", 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        @(negedge CLK); ihit = 1'b1;
        #1 chk_all("ld5.rt_tick", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        @(negedge CLK);
        #1 chk_all("ld5.rt_fwd", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);

        // Load into r0 never hazards or forwards
        @(negedge CLK); id_is_load = 1'b1; id_dest = 5'd0; id_instr = 32'd0; id_uses_rt = 1'b0;
        @(negedge CLK); id_is_load = 1'b0; id_uses_rt = 1'b1;
        #1 chk_all("ld0.ex", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge CLK);
        #1 chk_all("ld0.mem", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

        // Taken branch over a load-use hazard; flushed load r3 must not be tracked
        @(negedge CLK); id_is_load = 1'b1; id_dest = 5'd8; id_instr = 32'd0; id_uses_rt = 1'b0;
        @(negedge CLK); id_instr = mk(5'd8, 5'd0); branch_taken = 1'b1; id_is_load = 1'b1; id_dest = 5'd3;
        #1 chk_all("br.flush", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        @(negedge CLK); branch_taken = 1'b0; id_is_load = 1'b0; id_dest = 5'd0;
        id_instr = mk(5'd3, 5'd8); id_uses_rt = 1'b1;
        #1 chk_all("br.after", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);

        // Halt: same-cycle tick, then frozen
        @(negedge CLK); halt = 1'b1; id_instr = 32'd0; id_uses_rt = 1'b0;
        #1 chk_all("halt.edge", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge CLK); halt = 1'b0; dhit = 1'b1; dmem_req = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk_all("halt.frozen", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
            @(negedge CLK);
        end
        nRST = 1'b0;
        #1 chk_all("halt.reset", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge CLK); nRST = 1'b1; ihit = 1'b0; dhit = 1'b0; dmem_req = 1'b0; branch_taken = 1'b0;
        #1 chk_all("halt.rerun", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge CLK); ihit = 1'b1;
        #1 chk("halt.rerun_tick", {3'd0, tick}, 4'd1);

        // Reset mid-wait discards the held ihit
        @(negedge CLK); dmem_req = 1'b1;
        #1 chk("midrst.wait", {3'd0, tick}, 4'd0);
        @(negedge CLK); nRST = 1'b0; ihit = 1'b0;
        @(negedge CLK); nRST = 1'b1; dhit = 1'b1;
        #1 chk("midrst.no_tick", {3'd0, tick}, 4'd0);
        @(negedge CLK); dhit = 1'b0; ihit = 1'b1;
        #1 chk("midrst.fresh_ihit", {3'd0, tick}, 4'd1);

        @(negedge CLK);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Control generator for the pipeline register bank: produces the `tick` advance enable, load-use stall (`lw_hazard`), late-load forward select (`lw_later_hazard`) and branch flush (`branching`) that the IF/ID/EX/MEM registers consume. It sits between the cache hit signals, the decode/execute stage outputs and the pipeline registers. It merges non-simultaneous instruction and data hits, tracks in-flight loads over two stages, and freezes the pipeline permanently on halt.

## Interface
Parameters:
- `REGW`, 5, register index width
- `WORD`, 32, instruction width

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge
- `nRST`  in  1  asynchronous, active-low reset
- `ihit`  in  1  instruction fetch completed this cycle (single-cycle pulse or level)
- `dhit`  in  1  data access completed this cycle
- `dmem_req`  in  1  MEM stage holds a load or store (`EX_MemToReg_OUT | EX_MemWrite_OUT`)
- `id_instr`  in  WORD  instruction in decode; rs = [25:21], rt = [20:16]
- `id_uses_rt`  in  1  decode instruction reads rt as a source
- `id_is_load`  in  1  decode instruction is a load
- `id_dest`  in  REGW  destination register of the decode instruction
- `branch_taken`  in  1  EX stage resolved a taken branch or jump
- `halt`  in  1  halt instruction has reached MEM (`MEM_halt_OUT`)
- `tick`  out  1  pipeline registers latch this cycle
- `lw_hazard`  out  1  insert a bubble into EX and hold IF/ID and PC
- `lw_later_hazard`  out  2  bit0: rs forwards from MEM read data; bit1: rt does
- `branching`  out  1  flush IF/ID and ID/EX on this tick
- `halted`  out  1  pipeline permanently frozen

## Operation
- Hit merge: flags `i_done`, `d_done`.
  - `i_ok = ihit | i_done`
  - `d_ok = !dmem_req | dhit | d_done`
  - `tick = i_ok & d_ok & !halted`
  - When `tick=0`: `ihit` sets `i_done`; `dhit & dmem_req` sets `d_done`.
  - When `tick=1`: both flags clear.
- Load tracker: two entries, `ex_ld` and `mem_ld`, each holding {valid, reg}.
  - On `tick`: `mem_ld <= ex_ld`.
  - On `tick`: `ex_ld <= {id_is_load & !lw_hazard & !branching, id_dest}`, so a bubble or a flushed instruction never enters the tracker as a load.
- `lw_hazard = ex_ld.valid & ex_ld.reg!=0 & (rs==ex_ld.reg | (id_uses_rt & rt==ex_ld.reg)) & !branching`
- `lw_later_hazard[0] = mem_ld.valid & mem_ld.reg!=0 & rs==mem_ld.reg`
- `lw_later_hazard[1] = mem_ld.valid & mem_ld.reg!=0 & id_uses_rt & rt==mem_ld.reg`
- `branching = branch_taken & !halted`. Branch takes priority over a load-use stall: the stalled instruction is being flushed anyway.
- State machine:
  - RUN: normal operation.
  - RUN -> HALT: on any cycle with `halt=1`.
  - HALT: `halted=1`, `tick=0`, all other outputs 0, flags and tracker frozen. HALT is exited only by reset.

## Timing
- While `nRST=0`: all flags clear, both tracker entries are invalid (reg 0), state is RUN, and every output is 0.
- Outputs are combinational from inputs plus registered state, so there is zero added latency: a cycle with `ihit` and `dhit` present together ticks in that same cycle.
- Hits arriving in separate cycles: `tick` asserts in the cycle the second hit arrives. The earlier hit is held in its flag for any number of cycles.
- `dmem_req=0`: `tick` follows `i_ok` alone, and `dhit` is ignored.
- `lw_hazard` lasts exactly one tick. After that tick `ex_ld` is invalid, and the load moves to `mem_ld`, raising `lw_later_hazard` for the same consumer in the next cycle.
- Register 0 never causes a hazard or forward.
- `halt` arriving in the same cycle as a tick: that tick occurs, and HALT takes effect from the next cycle.
- Reset asserted mid-wait: the flags are discarded, and no tick is produced after reset releases until a fresh `ihit`.

## Test plan
- Reset then `ihit=1`, `dmem_req=0` for 4 cycles -> `tick=1` in each of the 4 cycles; `lw_hazard=0`, `lw_later_hazard=00`, `branching=0`.
- `dmem_req=1`, `ihit` at cycle 2, `dhit` at cycle 5 -> `tick=0` in cycles 2-4 and `tick=1` only in cycle 5. Repeat with `dhit` first and `ihit` later -> same single tick at the later hit.
- Load to r8 decoded and ticked, then `add r9,r8,r1` (rs=8) in decode -> `lw_hazard=1` for one tick. The next cycle has `lw_hazard=0`, `lw_later_hazard=01`, and the following cycle has `00`.
- Load to r0, then an instruction with rs=0, rt=0, `id_uses_rt=1` -> `lw_hazard=0` and `lw_later_hazard=00`.
- `branch_taken=1` while `lw_hazard` conditions hold -> `branching=1`, `lw_hazard=0`, and `ex_ld` is invalid after the tick.
- `halt=1` for one cycle, then `ihit=1` and `dhit=1` held -> `halted=1` and `tick=0` indefinitely. Pulsing `nRST=0` returns the block to RUN with all outputs 0.
